gf_redirect_ctrl: RTL and testbench

Redirect controller that sequences the PC generator. It accepts exception and branch-resolve redirect requests over req/ack handshakes and buffers one of each. It issues exactly one redirect per sequence onto the PC generator's `sig_e`/`e_id` or `sig_recv_jmp`/`jmp_target` inputs, then holds a pipeline flush for a fixed number of cycles. It guarantees the PC generator never sees exception and jump strobes together.

---
 rtl/gf_redirect_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_gf_redirect_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_redirect_ctrl.sv
// gf_redirect_ctrl: sequences PC-generator redirects.
// Buffers one exception and one branch request, issues exactly one
// strobe per sequence (exception or jump, never both), then holds
// o_flush for FLUSH_CYCLES cycles before returning to IDLE.
// Optional interrupt source is enabled by defining GF_REDIR_IRQ_EN.
module gf_redirect_ctrl #(
  parameter int ADDR_LEN     = 64,
  parameter int FLUSH_CYCLES = 2
`ifdef GF_REDIR_IRQ_EN
  ,
  parameter logic [ADDR_LEN-1:0] IRQ_ID = ADDR_LEN'(64'h40)
`endif
) (
  input  logic                clk,
  input  logic                i_sig_rst_n,
  input  logic                i_exc_req,
  input  logic [ADDR_LEN-1:0] i_exc_id,
  output logic                o_exc_ack,
  input  logic                i_br_req,
  input  logic [ADDR_LEN-1:0] i_br_target,
  output logic                o_br_ack,
`ifdef GF_REDIR_IRQ_EN
  input  logic                i_irq,
  input  logic                i_irq_mask,
`endif
  output logic                o_sig_e,
  output logic [ADDR_LEN-1:0] o_e_id,
  output logic                o_sig_recv_jmp,
  output logic [ADDR_LEN-1:0] o_jmp_target,
  output logic                o_flush,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_E = 2'd1,
    ISSUE_J = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  // Counter reload value; the FLUSH state lasts (load + 1) cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                exc_v_reg;
  logic [ADDR_LEN-1:0] exc_id_reg;
  logic                br_v_reg;
  logic [ADDR_LEN-1:0] br_tgt_reg;
  logic                sig_e_reg, jmp_reg, flush_reg;
  logic [ADDR_LEN-1:0] e_id_reg, jmp_tgt_reg;
  logic [ADDR_LEN-1:0] e_id_next, jmp_tgt_next;
  logic                exc_clr, br_clr;
  logic                exc_ack, br_ack;

`ifdef GF_REDIR_IRQ_EN
  logic irq_q_reg, irq_pend_reg, src_irq_reg;
  logic irq_pend_next, src_irq_next, irq_clr, irq_rise;
`endif

  // Acks: an exception is taken whenever its slot is free; a branch only
  // in IDLE with nothing buffered and no exception competing this cycle.
  // Both are forced low while reset is asserted.
  always_comb begin
    exc_ack = i_sig_rst_n & i_exc_req & ~exc_v_reg;
    br_ack  = i_sig_rst_n & i_br_req & (state_reg == IDLE) &
              ~exc_v_reg & ~br_v_reg & ~exc_ack;
  end

  assign o_exc_ack = exc_ack;
  assign o_br_ack  = br_ack;

  // Next-state logic, slot clears and registered-output next values.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    exc_clr    = 1'b0;
    br_clr     = 1'b0;
`ifdef GF_REDIR_IRQ_EN
    src_irq_next = src_irq_reg;
    irq_clr      = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (exc_v_reg) begin
          state_next = ISSUE_E;
`ifdef GF_REDIR_IRQ_EN
          src_irq_next = 1'b0;
        end else if (irq_pend_reg && !i_irq_mask) begin
          state_next   = ISSUE_E;
          src_irq_next = 1'b1;
`endif
        end else if (br_v_reg) begin
          state_next = ISSUE_J;
        end
      end
      ISSUE_E: begin
        // Exception wins: any branch still buffered is stale.
`ifdef GF_REDIR_IRQ_EN
        exc_clr = ~src_irq_reg;
        irq_clr = src_irq_reg;
`else
        exc_clr = 1'b1;
`endif
        br_clr     = 1'b1;
        cnt_next   = FLUSH_LOAD;
        state_next = FLUSH;
      end
      ISSUE_J: begin
        br_clr     = 1'b1;
        cnt_next   = FLUSH_LOAD;
        state_next = FLUSH;
      end
      FLUSH: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Payloads are only non-zero alongside their strobe.
    e_id_next = '0;
    if (state_next == ISSUE_E) begin
`ifdef GF_REDIR_IRQ_EN
      e_id_next = src_irq_next ? IRQ_ID : exc_id_reg;
`else
      e_id_next = exc_id_reg;
`endif
    end
    jmp_tgt_next = (state_next == ISSUE_J) ? br_tgt_reg : '0;
  end

`ifdef GF_REDIR_IRQ_EN
  // Pending interrupt: set on an unmasked rising edge, dropped when
  // consumed or when the mask rises.
  always_comb begin
    irq_rise      = i_irq & ~irq_q_reg;
    irq_pend_next = ((irq_pend_reg & ~irq_clr) | irq_rise) & ~i_irq_mask;
  end

  // Interrupt edge detector, pending flag and issue-source record.
  always_ff @(posedge clk or negedge i_sig_rst_n) begin
    if (!i_sig_rst_n) begin
      irq_q_reg    <= 1'b0;
      irq_pend_reg <= 1'b0;
      src_irq_reg  <= 1'b0;
    end else begin
      irq_q_reg    <= i_irq;
      irq_pend_reg <= irq_pend_next;
      src_irq_reg  <= src_irq_next;
    end
  end
`endif

  // State, counter, request slots and registered PC-generator outputs.
  always_ff @(posedge clk or negedge i_sig_rst_n) begin
    if (!i_sig_rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      exc_v_reg   <= 1'b0;
      exc_id_reg  <= '0;
      br_v_reg    <= 1'b0;
      br_tgt_reg  <= '0;
      sig_e_reg   <= 1'b0;
      jmp_reg     <= 1'b0;
      flush_reg   <= 1'b0;
      e_id_reg    <= '0;
      jmp_tgt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (exc_ack) begin
        exc_v_reg  <= 1'b1;
        exc_id_reg <= i_exc_id;
      end else if (exc_clr) begin
        exc_v_reg <= 1'b0;
      end
      if (br_ack) begin
        br_v_reg   <= 1'b1;
        br_tgt_reg <= i_br_target;
      end else if (br_clr) begin
        br_v_reg <= 1'b0;
      end
      sig_e_reg   <= (state_next == ISSUE_E);
      jmp_reg     <= (state_next == ISSUE_J);
      flush_reg   <= (state_next == FLUSH);
      e_id_reg    <= e_id_next;
      jmp_tgt_reg <= jmp_tgt_next;
    end
  end

  assign o_sig_e        = sig_e_reg;
  assign o_e_id         = e_id_reg;
  assign o_sig_recv_jmp = jmp_reg;
  assign o_jmp_target   = jmp_tgt_reg;
  assign o_flush        = flush_reg;
  assign o_busy         = (state_reg != IDLE) | exc_v_reg | br_v_reg;

endmodule

// File: tb/tb_gf_redirect_ctrl.sv
// Testbench for gf_redirect_ctrl: directed scenarios plus randomized
// requesters, checked against a timeline model of redirect issue.
`timescale 1ns/1ps
module tb_gf_redirect_ctrl;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_req, br_req;
  logic [63:0] exc_id, br_tgt;
  logic        exc_ack, br_ack;
  logic        sig_e, jmp, flush, busy;
  logic [63:0] e_id, jmp_tgt;
`ifdef GF_REDIR_IRQ_EN
  logic        irq, irq_mask;
`endif

  always #5 clk = ~clk;

  gf_redirect_ctrl #(.ADDR_LEN(64), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .i_sig_rst_n    (rst_n),
    .i_exc_req      (exc_req),
    .i_exc_id       (exc_id),
    .o_exc_ack      (exc_ack),
    .i_br_req       (br_req),
    .i_br_target    (br_tgt),
    .o_br_ack       (br_ack),
`ifdef GF_REDIR_IRQ_EN
    .i_irq          (irq),
    .i_irq_mask     (irq_mask),
`endif
    .o_sig_e        (sig_e),
    .o_e_id         (e_id),
    .o_sig_recv_jmp (jmp),
    .o_jmp_target   (jmp_tgt),
    .o_flush        (flush),
    .o_busy         (busy)
  );

  // Timeline model: each accepted request becomes a scheduled strobe.
  typedef struct {
    int          cyc;
    bit          is_e;
    logic [63:0] val;
  } strobe_t;

  strobe_t     sched[$];
  int          t, prev_strobe, last_sched, exc_acc, exc_until, br_acc, br_until;
  int          n_vec = 0, n_bad = 0;
  int          jmp_seen, e_seen;
  // Requester state (held until ack; branch also dropped on flush).
  logic        exc_req_d, br_req_d;
  logic [63:0] exc_id_d, br_tgt_d;
  // Per-cycle observations for the directed scenarios.
  logic        obs_eack[0:63], obs_back[0:63], obs_se[0:63], obs_j[0:63];
  logic        obs_fl[0:63], obs_busy[0:63];
  logic [63:0] obs_eid[0:63], obs_tgt[0:63];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    sched.delete();
    t = 0; prev_strobe = -1000; last_sched = -1000;
    exc_acc = -1000; exc_until = -1000; br_acc = -1000; br_until = -1000;
    jmp_seen = 0; e_seen = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exc_req_d = 1'b0; br_req_d = 1'b0; exc_id_d = '0; br_tgt_d = '0;
    exc_req = 1'b0; br_req = 1'b0; exc_id = '0; br_tgt = '0;
`ifdef GF_REDIR_IRQ_EN
    irq = 1'b0; irq_mask = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: apply requester inputs, compare against the model,
  // then advance model and requesters.
  task automatic step();
    bit          e_hold, b_hold, st_busy, x_eack, x_back, x_se, x_j, x_fl;
    logic [63:0] x_eid, x_tgt;
    int          s;
    @(posedge clk); #1;
    exc_req = exc_req_d; exc_id = exc_id_d; br_req = br_req_d; br_tgt = br_tgt_d;
    #1;
    x_se = 0; x_j = 0; x_eid = '0; x_tgt = '0;
    if (sched.size() > 0 && sched[0].cyc == t) begin
      if (sched[0].is_e) begin x_se = 1; x_eid = sched[0].val; end
      else begin x_j = 1; x_tgt = sched[0].val; end
      prev_strobe = t;
      void'(sched.pop_front());
    end
    st_busy = (t >= prev_strobe) && (t <= prev_strobe + FC);
    x_fl    = (t >= prev_strobe + 1) && (t <= prev_strobe + FC);
    e_hold  = (exc_acc < t) && (t <= exc_until);
    b_hold  = (br_acc < t) && (t <= br_until);
    x_eack  = exc_req && !e_hold;
    x_back  = br_req && !st_busy && !e_hold && !b_hold && !x_eack;
    check("exc_ack", {63'd0, exc_ack}, {63'd0, x_eack});
    check("br_ack",  {63'd0, br_ack},  {63'd0, x_back});
    check("sig_e",   {63'd0, sig_e},   {63'd0, x_se});
    check("e_id",    e_id, x_eid);
    check("jmp",     {63'd0, jmp},     {63'd0, x_j});
    check("jmp_tgt", jmp_tgt, x_tgt);
    check("flush",   {63'd0, flush},   {63'd0, x_fl});
    check("busy",    {63'd0, busy},    {63'd0, st_busy | e_hold | b_hold});
    check("excl",    {63'd0, sig_e & jmp}, 64'd0);
    if (t < 64) begin
      obs_eack[t] = exc_ack; obs_back[t] = br_ack; obs_se[t] = sig_e; obs_j[t] = jmp;
      obs_fl[t] = flush; obs_busy[t] = busy; obs_eid[t] = e_id; obs_tgt[t] = jmp_tgt;
    end
    if (jmp) jmp_seen++;
    if (sig_e) e_seen++;
    if (x_eack) begin
      s = imax(t + 2, last_sched + FC + 2);
      sched.push_back('{s, 1'b1, exc_id});
      last_sched = s; exc_acc = t; exc_until = s;
      $display("txn exc id=%h acked cycle %0d, issue expected cycle %0d", exc_id, t, s);
    end
    if (x_back) begin
      s = t + 2;
      sched.push_back('{s, 1'b0, br_tgt});
      last_sched = s; br_acc = t; br_until = s;
      $display("txn br tgt=%h acked cycle %0d, issue expected cycle %0d", br_tgt, t, s);
    end
    if (exc_ack) exc_req_d = 1'b0;
    if (br_ack || flush) br_req_d = 1'b0;
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Acks and outputs while reset is asserted.
    rst_n = 1'b0; exc_req = 1'b1; br_req = 1'b1; exc_id = 64'h1; br_tgt = 64'h2;
`ifdef GF_REDIR_IRQ_EN
    irq = 1'b0; irq_mask = 1'b0;
`endif
    #3;
    check("rst_exc_ack", {63'd0, exc_ack}, 64'd0);
    check("rst_br_ack",  {63'd0, br_ack},  64'd0);
    check("rst_outs",    {58'd0, sig_e, jmp, flush, busy, |e_id, |jmp_tgt}, 64'd0);

    // Single branch from idle.
    do_reset();
    br_req_d = 1'b1; br_tgt_d = 64'h8000_1000;
    run(8);
    check("tp1_ack0",   {63'd0, obs_back[0]}, 64'd1);
    check("tp1_jmp2",   {63'd0, obs_j[2]},    64'd1);
    check("tp1_tgt2",   obs_tgt[2], 64'h8000_1000);
    check("tp1_flush34", {62'd0, obs_fl[3], obs_fl[4]}, 64'd3);
    check("tp1_busy5",  {63'd0, obs_busy[5]}, 64'd0);

    // Exception and branch together: only the exception goes through.
    do_reset();
    exc_req_d = 1'b1; exc_id_d = 64'h18; br_req_d = 1'b1; br_tgt_d = 64'h9000;
    run(10);
    check("tp2_eack", {63'd0, obs_eack[0]}, 64'd1);
    check("tp2_back", {63'd0, obs_back[0]}, 64'd0);
    check("tp2_se2",  {63'd0, obs_se[2]},   64'd1);
    check("tp2_eid2", obs_eid[2], 64'h18);
    check("tp2_nojmp", 64'(jmp_seen), 64'd0);

    // Branch captured, exception the following cycle.
    do_reset();
    br_req_d = 1'b1; br_tgt_d = 64'hA000;
    step();
    exc_req_d = 1'b1; exc_id_d = 64'h55;
    run(10);
    check("tp3_e_count", 64'(e_seen), 64'd1);

    // Exception arriving during FLUSH of a branch sequence.
    do_reset();
    br_req_d = 1'b1; br_tgt_d = 64'hB000;
    run(3);
    exc_req_d = 1'b1; exc_id_d = 64'h20;
    run(8);
    check("tp4_eack3", {63'd0, obs_eack[3]}, 64'd1);
    check("tp4_fl45",  {62'd0, obs_fl[4], obs_fl[5]}, 64'd2);
    check("tp4_se6",   {63'd0, obs_se[6]}, 64'd1);
    check("tp4_eid6",  obs_eid[6], 64'h20);

    // Reset in the middle of FLUSH.
    do_reset();
    br_req_d = 1'b1; br_tgt_d = 64'hC000;
    run(4);
    check("tp5_in_flush", {63'd0, flush}, 64'd1);
    rst_n = 1'b0; exc_req = 1'b1;
    #1;
    check("tp5_async_outs", {58'd0, sig_e, jmp, flush, busy, |e_id, |jmp_tgt}, 64'd0);
    check("tp5_async_ack", {63'd0, exc_ack}, 64'd0);
    do_reset();
    run(10);
    check("tp5_no_strobe", 64'(e_seen + jmp_seen), 64'd0);

    // Randomized requesters.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!exc_req_d && ($urandom % 8 == 0)) begin
        exc_req_d = 1'b1; exc_id_d = {$urandom, $urandom};
      end
      if (!br_req_d && !flush && ($urandom % 3 == 0)) begin
        br_req_d = 1'b1; br_tgt_d = {$urandom, $urandom};
      end
      step();
    end

`ifdef GF_REDIR_IRQ_EN
    // Interrupt edges with the mask clear and set.
    for (int m = 0; m < 2; m++) begin
      int first, cnt;
      logic [63:0] id_seen;
      do_reset();
      irq_mask = (m == 1);
      first = 100; cnt = 0; id_seen = '0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (c == 0) irq = 1'b1;
        #1;
        if (sig_e) begin
          cnt++;
          if (first == 100) begin first = c; id_seen = e_id; end
        end
      end
      if (m == 0) begin
        check("irq_lat", 64'(first), 64'd2);
        check("irq_id",  id_seen, 64'h40);
        check("irq_cnt", 64'(cnt), 64'd1);
      end else begin
        check("irq_masked_cnt", 64'(cnt), 64'd0);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
